merge8_pack: RTL and testbench

//  Serial-to-parallel bit packer; inverse of the byte-to-bits splitter.

---
 rtl/merge8_pack.sv | 84 ++++++++
 tb/tb_merge8_pack.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/merge8_pack.sv
// rtl/merge8_pack.sv - serial-to-parallel bit packer with a registered valid/ready word output
module merge8_pack #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    fill_cnt
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    fill_q, fill_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sr_shift;
    logic             in_acc;
    logic             at_last;

    generate
        if (LSB_FIRST) begin : g_lsb
            assign sr_shift = {in_bit, sr_q[WIDTH-1:1]};
        end else begin : g_msb
            assign sr_shift = {sr_q[WIDTH-2:0], in_bit};
        end
    endgenerate

    assign at_last  = (fill_q == LAST);
    // Only the word-completing bit can stall, and only while the output slot stays occupied.
    assign in_ready = !(at_last && out_valid_q && !out_ready);
    assign in_acc   = in_valid && in_ready;

    always_comb begin
        sr_d        = sr_q;
        fill_d      = fill_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (clr) begin
            sr_d   = '0;
            fill_d = '0;
        end else if (in_acc) begin
            if (at_last) begin
                out_data_d  = sr_shift;
                out_valid_d = 1'b1;
                sr_d        = '0;
                fill_d      = '0;
            end else begin
                sr_d   = sr_shift;
                fill_d = fill_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q        <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_merge8_pack.sv
// tb/tb_merge8_pack.sv - bench for merge8_pack (LSB-first and MSB-first instances)
module tb_merge8_pack;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, in_bit, in_valid, out_ready;
    logic       in_ready_l, out_valid_l, in_ready_m, out_valid_m;
    logic [7:0] out_data_l, out_data_m;
    logic [2:0] fill_l, fill_m;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    merge8_pack #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready_l), .out_data(out_data_l), .out_valid(out_valid_l),
        .out_ready(out_ready), .fill_cnt(fill_l)
    );

    merge8_pack #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready_m), .out_data(out_data_m), .out_valid(out_valid_m),
        .out_ready(out_ready), .fill_cnt(fill_m)
    );

    // Reference model: partial word is a list of arrived bits; words are assembled by arrival index.
    logic       m_bits[$];
    logic       m_valid;
    logic [7:0] m_data_l, m_data_m;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_valid  = 1'b0;
        m_data_l = 8'h00;
        m_data_m = 8'h00;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " out_valid_l"}, int'(out_valid_l), int'(m_valid));
        chk({tag, " out_valid_m"}, int'(out_valid_m), int'(m_valid));
        chk({tag, " out_data_l"}, int'(out_data_l), int'(m_data_l));
        chk({tag, " out_data_m"}, int'(out_data_m), int'(m_data_m));
        chk({tag, " fill_l"}, int'(fill_l), m_bits.size());
        chk({tag, " fill_m"}, int'(fill_m), m_bits.size());
    endtask

    // One clock: drive, check in_ready, advance model, sample after the edge.
    task automatic cycle(input logic b, input logic v, input logic r, input logic c,
                         input string tag);
        logic exp_ready;
        in_bit = b; in_valid = v; out_ready = r; clr = c;
        #1;
        exp_ready = !(m_bits.size() == 7 && m_valid && !r);
        chk({tag, " in_ready_l"}, int'(in_ready_l), int'(exp_ready));
        chk({tag, " in_ready_m"}, int'(in_ready_m), int'(exp_ready));
        if (m_valid && r) m_valid = 1'b0;
        if (c) begin
            m_bits.delete();
        end else if (v && exp_ready) begin
            m_bits.push_back(b);
            if (m_bits.size() == 8) begin
                for (int k = 0; k < 8; k++) begin
                    m_data_l[k]     = m_bits[k];
                    m_data_m[7 - k] = m_bits[k];
                end
                m_valid = 1'b1;
                m_bits.delete();
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    typedef struct {
        logic [7:0] arrival;   // arrival[k] is the k-th bit sent
        logic [7:0] exp_l;
        logic [7:0] exp_m;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'b1000_0101, 8'h85, 8'hA1};
        vecs[1] = '{8'h3C, 8'h3C, 8'h3C};
        vecs[2] = '{8'hC3, 8'hC3, 8'hC3};
        vecs[3] = '{8'h0F, 8'h0F, 8'hF0};
        vecs[4] = '{8'h01, 8'h01, 8'h80};
        vecs[5] = '{8'hFF, 8'hFF, 8'hFF};
        vecs[6] = '{8'h55, 8'h55, 8'hAA};
        vecs[7] = '{8'h12, 8'h12, 8'h48};

        rst_n = 1'b0; clr = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", int'(in_ready_l), 1);
        check_outputs("reset");
        rst_n = 1'b1;

        // T1/T2/T3: table words back-to-back, out_ready high
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) begin
                cycle(vecs[i].arrival[k], 1'b1, 1'b1, 1'b0, "table");
            end
            chk("table word_l", int'(out_data_l), int'(vecs[i].exp_l));
            chk("table word_m", int'(out_data_m), int'(vecs[i].exp_m));
            chk("table valid", int'(out_valid_l), 1);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, "drain");
        chk("drain valid", int'(out_valid_l), 0);
        chk("drain hold data", int'(out_data_l), 8'h12);

        // T4: backpressure with word 0x55 parked in the output register
        for (int k = 0; k < 8; k++) cycle(k[0] ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0, "t4a");
        for (int k = 0; k < 7; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0, "t4b");
        chk("t4 fill", int'(fill_l), 7);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, "t4stall");
        chk("t4 stall ready", int'(in_ready_l), 0);
        chk("t4 stall data", int'(out_data_l), 8'h55);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, "t4go");
        chk("t4 new valid", int'(out_valid_l), 1);
        chk("t4 new data_l", int'(out_data_l), 8'h7F);
        chk("t4 new data_m", int'(out_data_m), 8'hFE);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, "t4drain");

        // T5: clr after 5 bits, with a bit offered during clr
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b1, 1'b0, "t5a");
        cycle(1'b0, 1'b1, 1'b1, 1'b1, "t5clr");
        chk("t5 fill after clr", int'(fill_l), 0);
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1, 1'b1, 1'b0, "t5b");
        chk("t5 word", int'(out_data_l), 8'hFF);

        // T6: async reset mid-word while out_valid=1
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0, "t6a");
        chk("t6 pre valid", int'(out_valid_l), 1);
        chk("t6 pre fill", int'(fill_l), 4);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("t6rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) cycle(k < 4 ? 1'b1 : 1'b0, 1'b1, 1'b1, 1'b0, "t6b");
        chk("t6 word_l", int'(out_data_l), 8'h0F);
        chk("t6 word_m", int'(out_data_m), 8'hF0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
